// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int unsigned KEY_W     = 4;
  localparam logic [3:0]  COL_IDLE  = 4'b1111;
  localparam logic [3:0]  COL_FIRST = 4'b1110;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    RELEASE
  } state_e;

  // True when exactly one active-low line is asserted.
  function automatic logic single_low(input logic [3:0] v);
    return ($countones(~v) == 1);
  endfunction

  // Index of the (lowest-priority-last) asserted active-low line.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] rotate_col(input logic [3:0] col);
    return {col[2:0], col[3]};
  endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick.sv
// Free-running divider producing a one-cycle clock-enable each 2^SIZE cycles.
module scan_tick #(
  parameter int unsigned SIZE = 10
) (
  input  logic clk_pi,
  input  logic rst_n_pi,
  output logic tick_po
);

  logic [SIZE-1:0] cnt_q;
  logic [SIZE-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + SIZE'(1);
  end

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  // Pulse during the cycle whose closing edge wraps the counter to zero.
  assign tick_po = (cnt_q == '1);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with debounce and valid/ack key handoff.
// Optional KEYPAD_OVERRUN_EN: overwrite pending code and flag overrun_po.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 10,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic             clk_pi,
  input  logic             rst_n_pi,
  output logic [3:0]       col_po,
  input  logic [3:0]       row_pi,
  output logic [KEY_W-1:0] key_po,
  output logic             key_valid_po,
  input  logic             key_ack_pi
`ifdef KEYPAD_OVERRUN_EN
  ,
  output logic             overrun_po
`endif
);

  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);

  logic             tick;
  logic [3:0]       row_meta_q;
  logic [3:0]       rs_q;

  state_e           state_q, state_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       pat_q, pat_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             valid_q, valid_d;
`ifdef KEYPAD_OVERRUN_EN
  logic             overrun_q, overrun_d;
`endif

  logic             load;
  logic [KEY_W-1:0] load_code;
  logic [3:0]       cnt_inc;

  scan_tick #(.SIZE(SCAN_DIV)) u_scan_tick (
    .clk_pi   (clk_pi),
    .rst_n_pi (rst_n_pi),
    .tick_po  (tick)
  );

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      row_meta_q <= '1;
      rs_q       <= '1;
    end else begin
      row_meta_q <= row_pi;
      rs_q       <= row_meta_q;
    end
  end

  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    pat_d     = pat_q;
    row_idx_d = row_idx_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_code = '0;

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (col_q == COL_IDLE) begin
            col_d = COL_FIRST;
          end else if (single_low(rs_q)) begin
            pat_d     = rs_q;
            row_idx_d = low_index(rs_q);
            // Single-sample debounce accepts on the detection tick itself.
            if (DB_TARGET == 4'd1) begin
              load      = 1'b1;
              load_code = {low_index(rs_q), low_index(col_q)};
              cnt_d     = '0;
              state_d   = RELEASE;
            end else begin
              cnt_d   = 4'd1;
              state_d = DEBOUNCE;
            end
          end else begin
            col_d = rotate_col(col_q);
          end
        end

        DEBOUNCE: begin
          if (rs_q == pat_q) begin
            if (cnt_inc == DB_TARGET) begin
              load      = 1'b1;
              load_code = {row_idx_q, low_index(col_q)};
              cnt_d     = '0;
              state_d   = RELEASE;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            state_d = SCAN;
            col_d   = rotate_col(col_q);
          end
        end

        RELEASE: begin
          if (rs_q == 4'b1111) begin
            if (cnt_inc == DB_TARGET) begin
              cnt_d   = '0;
              state_d = SCAN;
              col_d   = rotate_col(col_q);
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end

        default: begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_d   = key_q;
    valid_d = valid_q;
`ifdef KEYPAD_OVERRUN_EN
    overrun_d = overrun_q;
`endif

    if (valid_q && key_ack_pi) begin
      valid_d = 1'b0;
`ifdef KEYPAD_OVERRUN_EN
      overrun_d = 1'b0;
`endif
    end

    // A load coinciding with an ack replaces the consumed code cleanly.
    if (load) begin
      if (!valid_q || key_ack_pi) begin
        key_d   = load_code;
        valid_d = 1'b1;
      end
`ifdef KEYPAD_OVERRUN_EN
      else begin
        key_d     = load_code;
        overrun_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      state_q   <= SCAN;
      col_q     <= COL_IDLE;
      pat_q     <= '1;
      row_idx_q <= '0;
      cnt_q     <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
`ifdef KEYPAD_OVERRUN_EN
      overrun_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      pat_q     <= pat_d;
      row_idx_q <= row_idx_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
`ifdef KEYPAD_OVERRUN_EN
      overrun_q <= overrun_d;
`endif
    end
  end

  assign col_po       = col_q;
  assign key_po       = key_q;
  assign key_valid_po = valid_q;
`ifdef KEYPAD_OVERRUN_EN
  assign overrun_po   = overrun_q;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 keypad matrix.
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key;
  logic        valid;
  logic        ack;
  logic        overrun;
  logic [15:0] pressed;

  int unsigned tests_run;
  int unsigned tests_failed;
  logic [3:0]  sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV       (2),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk_pi       (clk),
    .rst_n_pi     (rst_n),
    .col_po       (col),
    .row_pi       (row),
    .key_po       (key),
    .key_valid_po (valid),
    .key_ack_pi   (ack)
`ifdef KEYPAD_OVERRUN_EN
    ,
    .overrun_po   (overrun)
`endif
  );

`ifndef KEYPAD_OVERRUN_EN
  assign overrun = 1'b0;
`endif

  // Key code r*4+c shorts row r to column c.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_col(input logic [3:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (col === target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok && col === target) ok = 1'b1;
  endtask

  task automatic test_reset;
    logic [3:0] seq [4];
    seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst_n = 1'b0; ack = 1'b0; pressed = '0;
    cyc(2);
    tests_run++; if (col !== 4'b1111) begin tests_failed++; $display("FAIL reset_col: got %b expected 1111", col); end
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", valid); end
    tests_run++; if (key !== 4'h0) begin tests_failed++; $display("FAIL reset_key: got %h expected 0", key); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rst_n = 1'b1;
    cyc(3);
    tests_run++; if (col !== 4'b1111) begin tests_failed++; $display("FAIL pre_tick_col: got %b expected 1111", col); end
    cyc(1);
    tests_run++; if (col !== 4'b1110) begin tests_failed++; $display("FAIL first_tick_col: got %b expected 1110", col); end
    for (int i = 0; i < 4; i++) begin
      cyc(4);
      tests_run++;
      if (col !== seq[i] || valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rotate_%0d: got col=%b valid=%b expected col=%b valid=0", i, col, valid, seq[i]);
      end
    end
  endtask

  task automatic test_clean_press;
    bit ok;
    int n;
    int extra_valid;
    int col_moves;
    logic [3:0] exp_code;
    pressed[6] = 1'b1;
    sb.push_back(4'h6);
    wait_col(4'b1011, 40, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL press_reach_col2: got %b expected 1011", col); end
    n = 0;
    while (n < 30 && valid !== 1'b1) begin
      cyc(1);
      n++;
    end
    tests_run++; if (n != 12) begin tests_failed++; $display("FAIL press_latency: got %0d cycles expected 12", n); end
    tests_run++; if (col !== 4'b1011) begin tests_failed++; $display("FAIL press_frozen_col: got %b expected 1011", col); end
    exp_code = (sb.size() > 0) ? sb.pop_front() : 4'hx;
    tests_run++; if (key !== exp_code) begin tests_failed++; $display("FAIL press_code: got %h expected %h", key, exp_code); end
    cyc(3);
    tests_run++; if (valid !== 1'b1 || key !== 4'h6) begin tests_failed++; $display("FAIL press_hold_valid: got valid=%b key=%h expected 1/6", valid, key); end
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL ack_clears: got %b expected 0", valid); end
    tests_run++; if (key !== 4'h6) begin tests_failed++; $display("FAIL key_after_ack: got %h expected 6", key); end
    extra_valid = 0; col_moves = 0;
    for (int i = 0; i < 80; i++) begin
      cyc(1);
      if (valid === 1'b1) extra_valid++;
      if (col !== 4'b1011) col_moves++;
    end
    tests_run++; if (extra_valid != 0) begin tests_failed++; $display("FAIL no_repeat: got %0d valid cycles expected 0", extra_valid); end
    tests_run++; if (col_moves != 0) begin tests_failed++; $display("FAIL release_frozen: got %0d moved cycles expected 0", col_moves); end
    pressed[6] = 1'b0;
    wait_col(4'b0111, 40, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL release_resume: got %b expected 0111", col); end
  endtask

  task automatic test_bounce;
    bit ok;
    int extra_valid;
    pressed[6] = 1'b1;
    wait_col(4'b1011, 40, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL bounce_reach_col2: got %b expected 1011", col); end
    cyc(9);
    pressed[6] = 1'b0;
    cyc(3);
    tests_run++; if (col !== 4'b0111) begin tests_failed++; $display("FAIL bounce_resume_col: got %b expected 0111", col); end
    extra_valid = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (valid === 1'b1) extra_valid++;
    end
    tests_run++; if (extra_valid != 0) begin tests_failed++; $display("FAIL bounce_no_key: got %0d valid cycles expected 0", extra_valid); end
  endtask

  task automatic test_ghost;
    bit ok;
    int extra_valid;
    pressed[4] = 1'b1;
    pressed[12] = 1'b1;
    wait_col(4'b0111, 40, ok);
    wait_col(4'b1110, 40, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL ghost_reach_col0: got %b expected 1110", col); end
    cyc(4);
    tests_run++; if (col !== 4'b1101) begin tests_failed++; $display("FAIL ghost_keeps_rotating: got %b expected 1101", col); end
    extra_valid = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1);
      if (valid === 1'b1) extra_valid++;
    end
    tests_run++; if (extra_valid != 0) begin tests_failed++; $display("FAIL ghost_no_key: got %0d valid cycles expected 0", extra_valid); end
    pressed = '0;
  endtask

  task automatic test_overrun;
    bit ok;
    int n;
    logic [3:0] exp_code;
    pressed[6] = 1'b1;
    sb.push_back(4'h6);
    n = 0;
    while (n < 200 && valid !== 1'b1) begin
      cyc(1);
      n++;
    end
    exp_code = (sb.size() > 0) ? sb.pop_front() : 4'hx;
    tests_run++; if (valid !== 1'b1 || key !== exp_code) begin tests_failed++; $display("FAIL ovr_first_key: got valid=%b key=%h expected 1/%h", valid, key, exp_code); end
    pressed[6] = 1'b0;
    wait_col(4'b0111, 60, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL ovr_resume: got %b expected 0111", col); end
    pressed[15] = 1'b1;
`ifdef KEYPAD_OVERRUN_EN
    sb.push_back(4'hF);
    n = 0;
    while (n < 200 && key === 4'h6) begin
      cyc(1);
      n++;
    end
    exp_code = (sb.size() > 0) ? sb.pop_front() : 4'hx;
    tests_run++; if (key !== exp_code) begin tests_failed++; $display("FAIL ovr_overwrite: got %h expected %h", key, exp_code); end
    tests_run++; if (overrun !== 1'b1 || valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag: got overrun=%b valid=%b expected 1/1", overrun, valid); end
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    tests_run++; if (valid !== 1'b0 || overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_ack: got valid=%b overrun=%b expected 0/0", valid, overrun); end
`else
    cyc(120);
    tests_run++; if (key !== 4'h6 || valid !== 1'b1) begin tests_failed++; $display("FAIL drop_keeps_key: got key=%h valid=%b expected 6/1", key, valid); end
    tests_run++; if (col !== 4'b0111) begin tests_failed++; $display("FAIL drop_fsm_frozen: got %b expected 0111", col); end
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL drop_ack: got %b expected 0", valid); end
`endif
    pressed[15] = 1'b0;
    wait_col(4'b1110, 60, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL ovr_release_resume: got %b expected 1110", col); end
  endtask

  task automatic test_async_reset;
    bit ok;
    pressed[6] = 1'b1;
    wait_col(4'b1011, 60, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL ares_reach_col2: got %b expected 1011", col); end
    cyc(6);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (col !== 4'b1111 || valid !== 1'b0 || key !== 4'h0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got col=%b valid=%b key=%h ovr=%b expected 1111/0/0/0", col, valid, key, overrun);
    end
    pressed = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    tests_run++; if (col !== 4'b1111) begin tests_failed++; $display("FAIL ares_pre_tick: got %b expected 1111", col); end
    cyc(1);
    tests_run++; if (col !== 4'b1110) begin tests_failed++; $display("FAIL ares_restart: got %b expected 1110", col); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    ack = 1'b0;
    pressed = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_ghost();
    test_overrun();
    test_async_reset();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drained: got %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment driver. Where the display driver rotates anodes and drives segments, this block rotates active-low column drives across a 4x4 matrix keypad and senses the rows.
- Each column is sensed on a divided scan tick. The block debounces one key and presents its 4-bit hex code to the calculator datapath over a valid/ack handshake.
- The code feeds straight into segmentFormatter-style hex display.

Parameters:
- SCAN_DIV, 10: scan tick every 2^SCAN_DIV clk_pi cycles; each column dwell lasts one tick period.
- DEBOUNCE_SCANS, 4: consecutive identical samples required to accept a press or a release; legal range 1..15.

Ports:
- clk_pi  in  1  system clock (50 MHz board clock)
- rst_n_pi  in  1  asynchronous, active-low reset
- col_po  out  4  column drive, active low, one-hot-zero while scanning
- row_pi  in  4  row sense, active low (external pull-ups), asynchronous to clk_pi
- key_po  out  4  accepted key code = {row_idx[1:0], col_idx[1:0]}
- key_valid_po  out  1  key_po holds an unconsumed code
- key_ack_pi  in  1  consumer accepts key_po in a cycle where key_valid_po=1
- overrun_po  out  1  present only with KEYPAD_OVERRUN_EN

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-debounce):
  - col_po=4'b1111, key_po=0, key_valid_po=0, overrun_po=0.
  - Row synchronizer=4'b1111, tick counter=0, debounce count=0, state=SCAN.
- Row input: row_pi passes through a 2-flop synchronizer. All decisions use the synchronized value rs.
- Tick: single-cycle pulse when the free-running SCAN_DIV-bit counter wraps to 0. All state changes except handshake and reset occur only on tick cycles.
- SCAN:
  - Leaving reset, the first tick drives col_po=1110.
  - On later ticks, rs is evaluated against the current column and the column then rotates 1110->1101->1011->0111->1110.
  - If exactly one rs bit is low: latch col_idx (0..3 for the low col bit), row_idx, and the rs pattern; set debounce count=1; freeze the column; go to DEBOUNCE.
  - Zero or two or more rows low: ignored; keep rotating.
- DEBOUNCE:
  - Each tick, rs matches the latched pattern -> count+1. rs differs -> count=0, go to SCAN, and rotate the column on that same tick.
  - When count reaches DEBOUNCE_SCANS: load key_po, key_valid_po=1, count=0, go to RELEASE.
  - key_valid_po is visible on the cycle after that tick.
  - With DEBOUNCE_SCANS=1, the SCAN detection tick itself loads the code.
- RELEASE:
  - Column stays frozen. Each tick with rs=4'b1111 -> count+1; any low row -> count=0.
  - At DEBOUNCE_SCANS: go to SCAN with the column advancing to the next one in rotation.
  - A held key yields exactly one code; there is no auto-repeat.
- Handshake:
  - key_valid_po=1 and key_ack_pi=1 in a cycle -> key_valid_po=0 next cycle.
  - Ack while key_valid_po=0 is ignored.
  - key_po stays stable while valid=1 (except overrun, below) and keeps its last value after ack.
  - Load and ack in the same cycle: the load wins, valid stays 1, and it is not an overrun.
- Pending key when a new key is accepted (valid=1, no ack in the load cycle): handled per the Optional Feature.
- Column wrap: the index wraps 3->0, and the counter wraps modulo 2^SCAN_DIV.

Optional Feature:
- Macro KEYPAD_OVERRUN_EN.
- Defined:
  - A new accept while a code is pending overwrites key_po and sets sticky overrun_po.
  - overrun_po clears on the cycle after the next ack.
  - The overrun_po port exists.
- Undefined:
  - The new code is dropped: key_po and valid are unchanged, and the FSM still proceeds to RELEASE.
  - No overrun_po port.

Decomposition:
- Package keypad_pkg holds:
  - the state enum {SCAN, DEBOUNCE, RELEASE}
  - COL_IDLE=4'b1111 and COL_FIRST=4'b1110
  - KEY_W=4
- Sub-module scan_tick: parameter SIZE, ports clk_pi, rst_n_pi, tick_po. It is the reset-capable clock-enable generator and is also reusable for the display driver.

Test Plan:
- Bench config: SCAN_DIV=2 (tick every 4 cycles), DEBOUNCE_SCANS=3 unless stated.
- Reset/idle: rows all high -> col_po 1111 until the first tick, then 1110,1101,1011,0111,1110 on successive ticks; key_valid_po stays 0.
- Clean press: rs=4'b1101 only while col_po=1011 (row1, col2) -> column freezes at 1011; key_po=4'h6 and valid=1 the cycle after the third matching tick; ack -> valid=0 next cycle; holding the key 20 ticks produces no second code.
- Bounce: press row1/col2 for 2 ticks then release -> no valid; SCAN resumes with col_po=0111 on the mismatch tick.
- Ghost: rs=4'b0101 on column 0 -> ignored; rotation continues.
- Overrun: key 6 accepted and left unacked, released, then row3/col3 (code F) pressed.
  - Without KEYPAD_OVERRUN_EN: key_po stays 6.
  - With KEYPAD_OVERRUN_EN: key_po=F and overrun_po=1; ack clears valid and overrun_po.
- Async reset: assert rst_n_pi mid-DEBOUNCE between clock edges -> all outputs at reset values before the next edge; deassert -> normal scan restarts from 1110.
